// File: rtl/graphic_instruction_queue.sv
// graphic_instruction_queue: frame-synchronous command FIFO between the CPU and the GPU.
// The processor may write instructions at any time. Exactly one instruction is
// released per video frame, at the falling edge of V_SYNC, and it is held on
// INSTRUCTION until the next release.
// Ports:
//   CLK, RST      clock, synchronous active-high reset
//   WR_EN/WR_DATA processor write strobe and instruction
//   CLR           flush of queue contents and the overflow flag
//   V_SYNC        active-low vertical sync from the VGA controller
//   INSTRUCTION   applied instruction; INSTR_STROBE pulses when it changes
//   INSTR_VALID   an instruction has been applied since reset
//   FULL/EMPTY/COUNT queue occupancy; OVERFLOW sticky dropped-write flag
module graphic_instruction_queue #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned WIDTH = 32
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     WR_EN,
   input  logic [WIDTH-1:0]         WR_DATA,
   input  logic                     CLR,
   input  logic                     V_SYNC,
   output logic [WIDTH-1:0]         INSTRUCTION,
   output logic                     INSTR_STROBE,
   output logic                     INSTR_VALID,
   output logic                     FULL,
   output logic                     EMPTY,
   output logic [$clog2(DEPTH):0]   COUNT,
   output logic                     OVERFLOW
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ARMED = 2'd1,
      S_LOAD  = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wp;
   logic [PW-1:0]    rp;
   logic             vs_d;
   logic             frame_edge;
   logic             wr_accept;
   logic             pop;
   logic [CW-1:0]    count_next;

   // Edge detect, write acceptance (against registered FULL) and occupancy update
   always_comb begin
      frame_edge = vs_d & ~V_SYNC;
      wr_accept  = WR_EN & ~FULL;
      pop        = (state == S_LOAD);
      count_next = COUNT + CW'(wr_accept) - CW'(pop);
   end

   // Storage array; not reset, contents are only meaningful between WP and RP
   always_ff @(posedge CLK) begin
      if (!RST && !CLR && wr_accept) begin
         mem[wp] <= WR_DATA;
      end
   end

   // Control: pointers, occupancy flags, release FSM and output registers
   always_ff @(posedge CLK) begin
      if (RST) begin
         state        <= S_IDLE;
         wp           <= '0;
         rp           <= '0;
         vs_d         <= 1'b1;
         COUNT        <= '0;
         EMPTY        <= 1'b1;
         FULL         <= 1'b0;
         OVERFLOW     <= 1'b0;
         INSTRUCTION  <= '0;
         INSTR_STROBE <= 1'b0;
         INSTR_VALID  <= 1'b0;
      end else begin
         vs_d         <= V_SYNC;
         INSTR_STROBE <= 1'b0;
         if (CLR) begin
            // Flush cancels any write or pop; the displayed instruction stays
            state    <= S_IDLE;
            wp       <= '0;
            rp       <= '0;
            COUNT    <= '0;
            EMPTY    <= 1'b1;
            FULL     <= 1'b0;
            OVERFLOW <= 1'b0;
         end else begin
            if (wr_accept) begin
               wp <= wp + PW'(1);
            end
            if (WR_EN && FULL) begin
               OVERFLOW <= 1'b1;
            end
            if (pop) begin
               INSTRUCTION  <= mem[rp];
               rp           <= rp + PW'(1);
               INSTR_STROBE <= 1'b1;
               INSTR_VALID  <= 1'b1;
            end
            COUNT <= count_next;
            EMPTY <= (count_next == '0);
            FULL  <= (count_next == CW'(DEPTH));

            case (state)
               // Frame edges seen with nothing queued are dropped, not remembered
               S_IDLE:  if (count_next != '0) state <= S_ARMED;
               S_ARMED: if (frame_edge) state <= S_LOAD;
               S_LOAD:  state <= (count_next != '0) ? S_ARMED : S_IDLE;
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_graphic_instruction_queue.sv
// Testbench for graphic_instruction_queue: a directed vector table followed by
// hand-written sequences for overflow, per-frame release and pointer wrap.
module tb_graphic_instruction_queue;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_en;
   logic [31:0] wr_data;
   logic        clr;
   logic        v_sync;
   logic [31:0] instruction;
   logic        instr_strobe;
   logic        instr_valid;
   logic        full;
   logic        empty;
   logic [4:0]  count;
   logic        overflow;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   graphic_instruction_queue #(.DEPTH(16), .WIDTH(32)) dut (
      .CLK          (clk),
      .RST          (rst),
      .WR_EN        (wr_en),
      .WR_DATA      (wr_data),
      .CLR          (clr),
      .V_SYNC       (v_sync),
      .INSTRUCTION  (instruction),
      .INSTR_STROBE (instr_strobe),
      .INSTR_VALID  (instr_valid),
      .FULL         (full),
      .EMPTY        (empty),
      .COUNT        (count),
      .OVERFLOW     (overflow)
   );

   typedef struct packed {
      logic [31:0] instr;
      logic        strobe;
      logic        valid;
      logic        full;
      logic        empty;
      logic [4:0]  count;
      logic        ovf;
   } outs_t;

   typedef struct packed {
      logic        rst;
      logic        clr;
      logic        wr;
      logic [31:0] data;
      logic        vs;
      outs_t       exp;
   } vec_t;

   localparam int NV = 34;
   vec_t vecs [NV];

   function automatic outs_t mo(input logic [31:0] i, input logic s, input logic v,
                                input logic f, input logic e, input logic [4:0] c,
                                input logic o);
      outs_t r;
      r.instr = i; r.strobe = s; r.valid = v; r.full = f;
      r.empty = e; r.count = c;  r.ovf = o;
      return r;
   endfunction

   function automatic vec_t mv(input logic r, input logic c, input logic w,
                               input logic [31:0] d, input logic vs, input outs_t e);
      vec_t x;
      x.rst = r; x.clr = c; x.wr = w; x.data = d; x.vs = vs; x.exp = e;
      return x;
   endfunction

   // Apply one cycle of inputs, then sample just after the active edge
   task automatic cyc(input logic r, input logic c, input logic w,
                      input logic [31:0] d, input logic vs);
      rst = r; clr = c; wr_en = w; wr_data = d; v_sync = vs;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input outs_t e);
      outs_t a;
      a = mo(instruction, instr_strobe, instr_valid, full, empty, count, overflow);
      n_vec++;
      if (a !== e) begin
         n_err++;
         $display("FAIL %s: got instr=%h stb=%b val=%b full=%b empty=%b cnt=%0d ovf=%b, want instr=%h stb=%b val=%b full=%b empty=%b cnt=%0d ovf=%b",
                  name, a.instr, a.strobe, a.valid, a.full, a.empty, a.count, a.ovf,
                  e.instr, e.strobe, e.valid, e.full, e.empty, e.count, e.ovf);
      end
   endtask

   // One frame: sync falls, release appears two cycles later, then sync idles high
   task automatic frame(input string name, input logic [31:0] d,
                        input logic [4:0] c, input logic o);
      cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      chk(name, mo(d, 1'b1, 1'b1, 1'b0, c == 5'd0, c, o));
      cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      chk({name, "_hold"}, mo(d, 1'b0, 1'b1, 1'b0, c == 5'd0, c, o));
      repeat (9) cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
   endtask

   initial begin
      // Reset with write pending, ordering, empty frame, same-cycle write+edge,
      // write during LOAD, flush, and flush cancelling a LOAD
      vecs[0]  = mv(1,0,1,32'h99,1, mo(32'h00,0,0,0,1,0,0));
      vecs[1]  = mv(1,0,1,32'h99,1, mo(32'h00,0,0,0,1,0,0));
      vecs[2]  = mv(0,0,1,32'h11,1, mo(32'h00,0,0,0,0,1,0));
      vecs[3]  = mv(0,0,1,32'h22,1, mo(32'h00,0,0,0,0,2,0));
      vecs[4]  = mv(0,0,1,32'h33,1, mo(32'h00,0,0,0,0,3,0));
      vecs[5]  = mv(0,0,0,32'h00,1, mo(32'h00,0,0,0,0,3,0));
      vecs[6]  = mv(0,0,0,32'h00,0, mo(32'h00,0,0,0,0,3,0));
      vecs[7]  = mv(0,0,0,32'h00,0, mo(32'h11,1,1,0,0,2,0));
      vecs[8]  = mv(0,0,0,32'h00,0, mo(32'h11,0,1,0,0,2,0));
      vecs[9]  = mv(0,0,0,32'h00,1, mo(32'h11,0,1,0,0,2,0));
      vecs[10] = mv(0,0,0,32'h00,0, mo(32'h11,0,1,0,0,2,0));
      vecs[11] = mv(0,0,0,32'h00,1, mo(32'h22,1,1,0,0,1,0));
      vecs[12] = mv(0,0,0,32'h00,1, mo(32'h22,0,1,0,0,1,0));
      vecs[13] = mv(0,0,0,32'h00,0, mo(32'h22,0,1,0,0,1,0));
      vecs[14] = mv(0,0,0,32'h00,0, mo(32'h33,1,1,0,1,0,0));
      vecs[15] = mv(0,0,0,32'h00,1, mo(32'h33,0,1,0,1,0,0));
      vecs[16] = mv(0,0,0,32'h00,0, mo(32'h33,0,1,0,1,0,0));
      vecs[17] = mv(0,0,0,32'h00,0, mo(32'h33,0,1,0,1,0,0));
      vecs[18] = mv(0,0,0,32'h00,1, mo(32'h33,0,1,0,1,0,0));
      vecs[19] = mv(0,0,0,32'h00,1, mo(32'h33,0,1,0,1,0,0));
      vecs[20] = mv(0,0,1,32'hAB,0, mo(32'h33,0,1,0,0,1,0));
      vecs[21] = mv(0,0,0,32'h00,0, mo(32'h33,0,1,0,0,1,0));
      vecs[22] = mv(0,0,0,32'h00,0, mo(32'h33,0,1,0,0,1,0));
      vecs[23] = mv(0,0,0,32'h00,1, mo(32'h33,0,1,0,0,1,0));
      vecs[24] = mv(0,0,0,32'h00,0, mo(32'h33,0,1,0,0,1,0));
      vecs[25] = mv(0,0,1,32'h55,0, mo(32'hAB,1,1,0,0,1,0));
      vecs[26] = mv(0,0,0,32'h00,1, mo(32'hAB,0,1,0,0,1,0));
      vecs[27] = mv(0,1,0,32'h00,1, mo(32'hAB,0,1,0,1,0,0));
      vecs[28] = mv(0,0,0,32'h00,0, mo(32'hAB,0,1,0,1,0,0));
      vecs[29] = mv(0,0,0,32'h00,1, mo(32'hAB,0,1,0,1,0,0));
      vecs[30] = mv(0,0,1,32'h66,1, mo(32'hAB,0,1,0,0,1,0));
      vecs[31] = mv(0,0,0,32'h00,0, mo(32'hAB,0,1,0,0,1,0));
      vecs[32] = mv(0,1,0,32'h00,0, mo(32'hAB,0,1,0,1,0,0));
      vecs[33] = mv(0,0,0,32'h00,1, mo(32'hAB,0,1,0,1,0,0));

      rst = 1'b1; clr = 1'b0; wr_en = 1'b0; wr_data = '0; v_sync = 1'b1;
      #1;

      for (int i = 0; i < NV; i++) begin
         cyc(vecs[i].rst, vecs[i].clr, vecs[i].wr, vecs[i].data, vecs[i].vs);
         chk($sformatf("vec%0d", i), vecs[i].exp);
      end

      // Overflow: 17 writes into a 16-deep queue, the last one is dropped
      for (int i = 0; i < 17; i++) begin
         cyc(1'b0, 1'b0, 1'b1, 32'(i), 1'b1);
         if (i < 16)
            chk($sformatf("ovf_wr%0d", i),
                mo(32'hAB, 1'b0, 1'b1, i == 15, 1'b0, 5'(i + 1), 1'b0));
         else
            chk("ovf_drop", mo(32'hAB, 1'b0, 1'b1, 1'b1, 1'b0, 5'd16, 1'b1));
      end
      for (int j = 0; j < 16; j++) begin
         frame($sformatf("ovf_rel%0d", j), 32'(j), 5'(15 - j), 1'b1);
      end
      cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      chk("ovf_clr", mo(32'd15, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0));

      // Pointer wrap: 20 write/release pairs walk both pointers past DEPTH
      for (int i = 0; i < 20; i++) begin
         cyc(1'b0, 1'b0, 1'b1, 32'h100 + 32'(i), 1'b1);
         chk($sformatf("wrap_wr%0d", i),
             mo((i == 0) ? 32'd15 : 32'h100 + 32'(i - 1), 1'b0, 1'b1, 1'b0, 1'b0, 5'd1, 1'b0));
         frame($sformatf("wrap_rel%0d", i), 32'h100 + 32'(i), 5'd0, 1'b0);
      end

      // Reset mid-stream returns everything to its initial values
      cyc(1'b0, 1'b0, 1'b1, 32'h77, 1'b1);
      cyc(1'b1, 1'b0, 1'b1, 32'h88, 1'b0);
      chk("final_rst", mo(32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
